// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: packs ADD/SUB/AND/ORR/LDUR/STUR/CBZ fields into LEGv8 words and streams them into imem
module legv8_instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     finish,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rn,
  input  logic [4:0]               in_rm,
  input  logic [18:0]              in_imm,
  output logic                     imem_we,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic [31:0]              imem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   word_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [10:0] r_opc;
  logic [31:0] word;
  logic accept, legal, last;
  assign in_ready = state == RUN && word_count < CW'(DEPTH) && !finish;
  assign accept = in_valid && in_ready;
  assign legal = in_op != 3'd7;
  assign last = word_count == CW'(DEPTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    r_opc = in_op == 3'd0 ? 11'b10001011000 :
            in_op == 3'd1 ? 11'b11001011000 :
            in_op == 3'd2 ? 11'b10001010000 : 11'b10101010000;
    word = in_op == 3'd6 ? {8'd180, in_imm, in_rd} :
           in_op[2] ? {in_op[0] ? 11'd1984 : 11'd1986, in_imm[8:0], 2'b00, in_rn, in_rd} :
           {r_opc, in_rm, 6'd0, in_rn, in_rd};
    state_nx = state;
    if (state == RUN) state_nx = (finish || (accept && legal && last)) ? DONE : RUN;
    else if (start) state_nx = RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= BASE;
      word_count <= '0;
      imem_we <= 1'b0;
      imem_addr <= BASE;
      imem_wdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      imem_we <= accept && legal;
      err <= accept && !legal;
      if (state != RUN && start) begin
        ptr <= BASE;
        word_count <= '0;
      end else if (accept && legal) begin
        ptr <= ptr + ADDR_W'(4);
        word_count <= word_count + 1'b1;
        imem_addr <= ptr;
        imem_wdata <= word;
      end
    end
  end
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb_legv8_instr_encoder: directed vectors checked against a field-level encoder model every cycle
module tb_legv8_instr_encoder;
  localparam int ADDR_W = 8, DEPTH = 4, BASE_ADDR = 0;
  logic clk = 0, reset = 1, start = 0, finish = 0, in_valid = 0;
  logic in_ready, imem_we, busy, done, err;
  logic [2:0] in_op = 0;
  logic [4:0] in_rd = 0, in_rn = 0, in_rm = 0;
  logic [18:0] in_imm = 0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [$clog2(DEPTH):0] word_count;
  int n_vec = 0, n_bad = 0;

  legv8_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Opcode values written as the instruction-set tables give them, combined arithmetically.
  function automatic logic [31:0] enc(input int op, input int rd, input int rn, input int rm, input int imm);
    longint w;
    case (op)
      0: w = 64'd1112 * (1 << 21) + rm * 65536 + rn * 32 + rd;
      1: w = 64'd1624 * (1 << 21) + rm * 65536 + rn * 32 + rd;
      2: w = 64'd1104 * (1 << 21) + rm * 65536 + rn * 32 + rd;
      3: w = 64'd1360 * (1 << 21) + rm * 65536 + rn * 32 + rd;
      4: w = 64'd1986 * (1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
      5: w = 64'd1984 * (1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
      default: w = 64'd180 * (1 << 24) + (imm % 524288) * 32 + rd;
    endcase
    return w[31:0];
  endfunction

  // Model: mode 0 idle, 1 loading, 2 finished.
  int m_st = 0, m_cnt = 0, m_ptr = 0;
  logic e_we = 0, e_err = 0, chk = 0;
  logic [31:0] e_addr = 0, e_wdata = 0;
  always @(posedge clk) begin
    int old;
    bit rdy;
    old = m_st;
    rdy = old == 1 && m_cnt < DEPTH && !finish;
    e_we = 0;
    e_err = 0;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_ptr = BASE_ADDR; e_addr = BASE_ADDR; e_wdata = 0; chk = 1;
    end else begin
      if (in_valid && rdy) begin
        if (in_op == 7) e_err = 1;
        else begin
          e_we = 1;
          e_addr = m_ptr;
          e_wdata = enc(in_op, in_rd, in_rn, in_rm, in_imm);
          m_ptr += 4;
          m_cnt++;
          if (m_cnt == DEPTH) m_st = 2;
        end
      end
      if (old == 1 && finish) m_st = 2;
      else if (old != 1 && start) begin m_st = 1; m_cnt = 0; m_ptr = BASE_ADDR; end
    end
  end

  always @(negedge clk) if (chk) begin
    cmp("imem_we", 32'(imem_we), 32'(e_we));
    cmp("err", 32'(err), 32'(e_err));
    cmp("busy", 32'(busy), 32'(m_st == 1));
    cmp("done", 32'(done), 32'(m_st == 2));
    cmp("word_count", 32'(word_count), m_cnt);
    cmp("in_ready", 32'(in_ready), 32'(m_st == 1 && m_cnt < DEPTH && !finish));
    cmp("imem_addr", 32'(imem_addr), e_addr);
    cmp("imem_wdata", imem_wdata, e_wdata);
  end

  task automatic tick;
    @(posedge clk);
    #1;
    start = 0;
    finish = 0;
  endtask

  task automatic fields(input logic [2:0] op, input logic [4:0] rd, rn, rm, input logic [18:0] imm);
    in_valid = 1; in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
  endtask

  initial begin
    int w;
    tick; tick;
    reset = 0;
    cmp("lit_rst_we", 32'(imem_we), 0);
    cmp("lit_rst_addr", 32'(imem_addr), BASE_ADDR);
    cmp("lit_rst_ready", 32'(in_ready), 0);
    // single ADD
    start = 1; tick;
    fields(0, 3, 1, 2, 0); tick; in_valid = 0;
    cmp("lit_add_we", 32'(imem_we), 1);
    cmp("lit_add_w", imem_wdata, 32'h8B020023);
    cmp("lit_add_a", 32'(imem_addr), 0);
    cmp("lit_add_wc", 32'(word_count), 1);
    finish = 1; tick;
    // back-to-back mixed formats, filling DEPTH
    start = 1; tick;
    fields(4, 5, 2, 0, 8); tick;
    cmp("lit_ldur_w", imem_wdata, 32'hF8408045);
    fields(5, 5, 2, 0, 8); tick;
    cmp("lit_stur_w", imem_wdata, 32'hF8008045);
    cmp("lit_stur_a", 32'(imem_addr), 4);
    fields(6, 7, 0, 0, 3); tick;
    cmp("lit_cbz_w", imem_wdata, 32'hB4000067);
    fields(1, 1, 1, 1, 0); tick; in_valid = 0;
    cmp("lit_sub_w", imem_wdata, 32'hCB010021);
    cmp("lit_sub_a", 32'(imem_addr), 12);
    cmp("lit_full_wc", 32'(word_count), 4);
    tick;
    cmp("lit_full_done", 32'(done), 1);
    // illegal op between two ADDs
    start = 1; tick;
    fields(0, 9, 10, 11, 0); tick;
    fields(7, 1, 2, 3, 0); tick;
    cmp("lit_err", 32'(err), 1);
    cmp("lit_err_we", 32'(imem_we), 0);
    fields(0, 4, 5, 6, 0); tick; in_valid = 0;
    cmp("lit_add2_a", 32'(imem_addr), 4);
    cmp("lit_add2_wc", 32'(word_count), 2);
    tick;
    finish = 1; tick;
    // valid held 6 cycles with DEPTH=4
    start = 1; tick;
    w = 0;
    fields(3, 2, 4, 6, 0);
    for (int i = 0; i < 6; i++) begin tick; if (imem_we) w++; end
    in_valid = 0;
    cmp("lit_full_writes", w, 4);
    cmp("lit_full_ready", 32'(in_ready), 0);
    cmp("lit_full_busy", 32'(busy), 0);
    // finish right after an accept, then restart
    start = 1; tick;
    fields(2, 1, 2, 3, 0); tick;
    fields(2, 4, 5, 6, 0); tick; in_valid = 0;
    finish = 1; tick;
    cmp("lit_fin_we", 32'(imem_we), 0);
    cmp("lit_fin_done", 32'(done), 1);
    start = 1; tick;
    cmp("lit_restart_wc", 32'(word_count), 0);
    fields(0, 3, 1, 2, 0); tick; in_valid = 0;
    cmp("lit_restart_a", 32'(imem_addr), BASE_ADDR);
    // reset right after an accept
    fields(1, 8, 9, 10, 0); tick; in_valid = 0;
    reset = 1; tick;
    cmp("lit_mid_rst_we", 32'(imem_we), 0);
    cmp("lit_mid_rst_wd", imem_wdata, 0);
    cmp("lit_mid_rst_busy", 32'(busy), 0);
    reset = 0;
    tick; tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/legv8_instr_encoder.md
Name: legv8_instr_encoder

Overview:
- Encoder counterpart to the core's instruction decoder: converts field-level instruction descriptions (operation, registers, immediate) into 32-bit LEGv8 machine words.
- Writes the words sequentially into instruction memory through a simple write port.
- Used by the testbench/boot loader path to fill instruction memory before the core runs.
- Covers exactly the subset the decoder supports: ADD, SUB, AND, ORR, LDUR, STUR, CBZ.

Parameters:
- ADDR_W, 8, width of imem_addr (byte address).
- DEPTH, 64, maximum number of words written per program; must be at most 2^(ADDR_W-2).
- BASE_ADDR, 0, byte address of the first word written; must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a program load.
- finish  input  1  one-cycle pulse; ends a program load early.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  encoder accepts fields this cycle.
- in_op  input  3  operation select: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 illegal.
- in_rd  input  5  Rd (R-type) or Rt (LDUR/STUR/CBZ).
- in_rn  input  5  Rn; ignored for CBZ.
- in_rm  input  5  Rm; R-type only.
- in_imm  input  19  immediate: [8:0] DT address for LDUR/STUR; [18:0] branch offset for CBZ.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  byte address of the write.
- imem_wdata  output  32  encoded instruction word.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- err  output  1  one-cycle pulse on an accepted illegal op.
- word_count  output  $clog2(DEPTH)+1  words written in the current/last load.

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready, imem_we, busy, done, err, word_count, imem_wdata all go to 0.
  - imem_addr goes to BASE_ADDR.
- FSM:
  - IDLE: start moves to RUN, clears word_count, sets the write pointer to BASE_ADDR.
  - RUN: finish moves to DONE, or DONE is entered automatically on the cycle after the DEPTH-th write.
  - DONE: start moves to RUN with the same clearing as from IDLE. start in RUN is ignored.
- in_ready is 1 only when the state is RUN, word_count < DEPTH, and no finish is being applied this cycle. Combinational on state and registers only, never on in_valid.
- Accept: in_valid && in_ready at edge N.
  - Legal op: imem_we=1 for exactly one cycle after edge N, with imem_wdata = encoded word and imem_addr = write pointer.
  - The pointer advances by 4 and word_count by 1 on the same edge.
  - Latency is 1 cycle; throughput is 1 word per cycle.
  - Illegal op (7): err=1 for one cycle after edge N, no write, pointer and count unchanged.
- Encoding:
  - R-type: [31:21] opcode, [20:16] Rm, [15:10] shamt = 0, [9:5] Rn, [4:0] Rd.
    - ADD 10001011000; SUB 11001011000; AND 10001010000; ORR 10101010000.
  - D-type: [31:21] opcode, [20:12] in_imm[8:0], [11:10] = 00, [9:5] Rn, [4:0] Rt.
    - LDUR 11111000010 (1986); STUR 11111000000 (1984).
  - CB-type: [31:24] 10110100 (180), [23:5] in_imm[18:0], [4:0] Rt.
  - Immediate bits not used by an op are ignored.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Simultaneous events:
  - finish and accept in the same cycle cannot occur, because in_ready is 0 while finish is applied.
  - If finish is applied in the cycle right after an accept, that word's write still completes; DONE is entered on the same edge.
  - start in RUN is ignored.
- Full: after the DEPTH-th accept, in_ready drops at the next edge and the state goes to DONE. The pointer does not wrap.
- Reset mid-load: any pending write is discarded (imem_we=0 on the next cycle) and the state returns to IDLE.

Test Plan:
- Reset, start, then ADD rd=3 rn=1 rm=2 → one cycle later imem_we=1, addr=0x00, wdata=0x8B020023; word_count=1.
- Back-to-back LDUR rd=5 rn=2 imm=8, STUR same fields, CBZ rd=7 imm=3, SUB rd=1 rn=1 rm=1 → writes 0xF8408045 @0x00, 0xF8008045 @0x04, 0xB4000067 @0x08, 0xCB010021 @0x0C on consecutive cycles; word_count=4.
- Op=7 between two ADDs → err pulses once; the ADDs land at 0x00 and 0x04; word_count=2.
- DEPTH=4, in_valid held high for 6 cycles → exactly 4 writes; in_ready=0 thereafter; done=1, busy=0.
- finish after 2 words, then start again → DONE entered; the new load restarts at BASE_ADDR with word_count=0.
- reset asserted in the cycle after an accept → no write occurs; all outputs at reset values; state IDLE.
